// File: rtl/parallel_pkg.sv
// Purpose : shared types and constants for the Raspberry Pi parallel-bus slave.
// Latency : n/a (types only).
// Backpressure: n/a.
package parallel_pkg;

  // Frame-level FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_WRITE  = 2'd2,
    ST_READ   = 2'd3
  } bus_state_t;

  // Bit of the header word that selects a host read (1) or host write (0).
  function automatic int hdr_read_bit(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose : single-clock first-word-fall-through FIFO with occupancy output.
// Latency : pushed word visible on rd_data one cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
//
// Ports: clk/rst_n (async active-low), wr_en/wr_data push side,
//        rd_en/rd_data/empty pop side (rd_data valid whenever !empty),
//        level = words currently stored (0..DEPTH).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = rd_en & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_push = wr_en & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/parallel_bus_slave.sv
// Purpose : Raspberry Pi parallel-header slave; framed host writes to RX FIFO, host reads from TX FIFO.
// Latency : SYNC_STAGES+2 CLK_50 cycles from pclk rise at the pin to RX update / new pdata_out.
// Backpressure: host has none (RX full drops + rx_overflow, TX empty reads 0 + tx_underflow); FPGA side valid/ready.
//
// Ports: CLK_50/iRSTN clock and async active-low reset; pclk/pcs_n/pdata_in host inputs
//        (asynchronous); pdata_out/pdata_oe host read bus and tristate enable;
//        rx_data/rx_valid/rx_ready FWFT RX stream; tx_data/tx_valid/tx_ready TX push;
//        rx_level RX occupancy; rx_overflow/tx_underflow sticky flags cleared by err_clr.
module parallel_bus_slave
  import parallel_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        CLK_50,
  input  logic                        iRSTN,
  input  logic                        pclk,
  input  logic                        pcs_n,
  input  logic [DATA_W-1:0]           pdata_in,
  output logic [DATA_W-1:0]           pdata_out,
  output logic                        pdata_oe,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic                        rx_overflow,
  output logic                        tx_underflow,
  input  logic                        err_clr
);

  localparam int HDR_BIT = hdr_read_bit(DATA_W);
  localparam int RX_LW   = $clog2(RX_DEPTH) + 1;
  localparam int TX_LW   = $clog2(TX_DEPTH) + 1;
  localparam logic [RX_LW-1:0] RX_FULL_LVL = RX_LW'(RX_DEPTH);
  localparam logic [TX_LW-1:0] TX_FULL_LVL = TX_LW'(TX_DEPTH);

  // ---------------------------------------------------------------------------
  // Input synchronisers. pcs_n idles high so its chain resets to 1, which keeps
  // reset release from looking like a chip-select falling edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] pclk_sync;
  logic [SYNC_STAGES-1:0] pcs_sync;
  logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
  logic                   pclk_d;
  logic                   pcs_d;

  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      pclk_sync <= '0;
      pcs_sync  <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_sync[i] <= '0;
      end
      pclk_d <= 1'b0;
      pcs_d  <= 1'b1;
    end else begin
      pclk_sync    <= {pclk_sync[SYNC_STAGES-2:0], pclk};
      pcs_sync     <= {pcs_sync[SYNC_STAGES-2:0], pcs_n};
      data_sync[0] <= pdata_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_sync[i] <= data_sync[i-1];
      end
      pclk_d <= pclk_sync[SYNC_STAGES-1];
      pcs_d  <= pcs_sync[SYNC_STAGES-1];
    end
  end

  logic              s_pclk;
  logic              s_pcs_n;
  logic [DATA_W-1:0] s_data;
  logic              strobe;
  logic              pcs_fall;

  assign s_pclk   = pclk_sync[SYNC_STAGES-1];
  assign s_pcs_n  = pcs_sync[SYNC_STAGES-1];
  assign s_data   = data_sync[SYNC_STAGES-1];
  // Chip select already high suppresses the strobe: deassert wins.
  assign strobe   = s_pclk & ~pclk_d & ~s_pcs_n;
  assign pcs_fall = ~s_pcs_n & pcs_d;

  // One registered stage between the strobe and the FSM so every host-visible
  // effect lands a fixed SYNC_STAGES+2 cycles after the pin edge.
  logic              strb_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      strb_q <= 1'b0;
      data_q <= '0;
    end else begin
      strb_q <= strobe;
      if (strobe) data_q <= s_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: state register / next state / outputs.
  // ---------------------------------------------------------------------------
  bus_state_t state;
  bus_state_t state_nxt;
  logic       strb_act;

  // A strobe reaching the FSM in the same cycle chip select is seen high is dropped.
  assign strb_act = strb_q & ~s_pcs_n;

  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pcs_fall) state_nxt = ST_HEADER;
      end
      ST_HEADER: begin
        if (s_pcs_n)       state_nxt = ST_IDLE;
        else if (strb_act) state_nxt = data_q[HDR_BIT] ? ST_READ : ST_WRITE;
      end
      ST_WRITE, ST_READ: begin
        if (s_pcs_n) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic rx_push;
  logic tx_load;
  logic out_clr;

  always_comb begin
    pdata_oe = (state == ST_READ);
    rx_push  = (state == ST_WRITE) & strb_act;
    // The TX head is loaded on the header strobe that enters READ and on
    // every strobe inside READ.
    tx_load  = strb_act & (((state == ST_HEADER) & data_q[HDR_BIT]) | (state == ST_READ));
    out_clr  = (state != ST_IDLE) & (state_nxt == ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  logic              rx_empty;
  logic              rx_pop;
  logic              rx_full;
  logic [DATA_W-1:0] tx_head;
  logic              tx_empty;
  logic              tx_pop;
  logic              tx_push;
  logic [TX_LW-1:0]  tx_level;

  assign rx_valid = ~rx_empty;
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_full  = (rx_level == RX_FULL_LVL);

  assign tx_ready = (tx_level != TX_FULL_LVL);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = tx_load & ~tx_empty;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (CLK_50),
    .rst_n   (iRSTN),
    .wr_en   (rx_push),
    .wr_data (data_q),
    .rd_en   (rx_pop),
    .rd_data (rx_data),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (CLK_50),
    .rst_n   (iRSTN),
    .wr_en   (tx_push),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  // ---------------------------------------------------------------------------
  // Host read bus and sticky error flags
  // ---------------------------------------------------------------------------
  logic ovf_set;
  logic unf_set;

  // A full RX still accepts when the FPGA side pops in the same cycle.
  assign ovf_set = rx_push & rx_full & ~rx_pop;
  assign unf_set = tx_load & tx_empty;

  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      pdata_out    <= '0;
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      // A word left on the bus at frame end is discarded, not returned to TX.
      if (out_clr)      pdata_out <= '0;
      else if (tx_load) pdata_out <= tx_empty ? '0 : tx_head;
      // A new error wins over a simultaneous clear.
      rx_overflow  <= (rx_overflow  & ~err_clr) | ovf_set;
      tx_underflow <= (tx_underflow & ~err_clr) | unf_set;
    end
  end

endmodule

// File: tb/tb_parallel_bus_slave.sv
module tb_parallel_bus_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pclk;
  logic        pcs_n;
  logic [15:0] hbus;
  logic        err_clr;

  // 8-bit default instance
  logic [7:0]  pdata_out8;
  logic        oe8;
  logic [7:0]  rx_data8;
  logic        rx_valid8;
  logic        rx_ready8;
  logic [7:0]  tx_data8;
  logic        tx_valid8;
  logic        tx_ready8;
  logic [4:0]  rx_level8;
  logic        ovf8;
  logic        unf8;

  // 16-bit, RX_DEPTH=4 instance sharing the host strobe/select
  logic [15:0] pdata_out16;
  logic        oe16;
  logic [15:0] rx_data16;
  logic        rx_valid16;
  logic        rx_ready16;
  logic [15:0] tx_data16;
  logic        tx_valid16;
  logic        tx_ready16;
  logic [2:0]  rx_level16;
  logic        ovf16;
  logic        unf16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parallel_bus_slave dut (
    .CLK_50(clk), .iRSTN(rst_n), .pclk(pclk), .pcs_n(pcs_n), .pdata_in(hbus[7:0]),
    .pdata_out(pdata_out8), .pdata_oe(oe8), .rx_data(rx_data8), .rx_valid(rx_valid8),
    .rx_ready(rx_ready8), .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .rx_level(rx_level8), .rx_overflow(ovf8), .tx_underflow(unf8), .err_clr(err_clr)
  );

  parallel_bus_slave #(.DATA_W(16), .RX_DEPTH(4)) dut16 (
    .CLK_50(clk), .iRSTN(rst_n), .pclk(pclk), .pcs_n(pcs_n), .pdata_in(hbus),
    .pdata_out(pdata_out16), .pdata_oe(oe16), .rx_data(rx_data16), .rx_valid(rx_valid16),
    .rx_ready(rx_ready16), .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
    .rx_level(rx_level16), .rx_overflow(ovf16), .tx_underflow(unf16), .err_clr(err_clr)
  );

  typedef struct {
    bit         cs_start;
    bit         cs_end;
    logic [7:0] din;
    logic       exp_oe;
    logic [7:0] exp_out;
    logic [4:0] exp_lvl;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  vec_t vecs [7];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic host_strobe(input logic [15:0] din);
    hbus = din;
    tick(2);
    pclk = 1'b1;
    tick(6);
    pclk = 1'b0;
    tick(6);
  endtask

  task automatic cs_begin();
    pcs_n = 1'b0;
    tick(6);
  endtask

  task automatic cs_finish();
    pcs_n = 1'b1;
    tick(6);
  endtask

  task automatic apply_vec(input int i);
    if (vecs[i].cs_start) cs_begin();
    host_strobe({8'h00, vecs[i].din});
    check($sformatf("vec%0d_oe", i),  32'(oe8),        32'(vecs[i].exp_oe));
    check($sformatf("vec%0d_out", i), 32'(pdata_out8), 32'(vecs[i].exp_out));
    check($sformatf("vec%0d_lvl", i), 32'(rx_level8),  32'(vecs[i].exp_lvl));
    check($sformatf("vec%0d_ovf", i), 32'(ovf8),       32'(vecs[i].exp_ovf));
    check($sformatf("vec%0d_unf", i), 32'(unf8),       32'(vecs[i].exp_unf));
    if (vecs[i].cs_end) cs_finish();
  endtask

  task automatic pop8(input string name, input logic [7:0] exp);
    check({name, "_vld"}, 32'(rx_valid8), 32'd1);
    check({name, "_dat"}, 32'(rx_data8),  32'(exp));
    rx_ready8 = 1'b1;
    tick(1);
    rx_ready8 = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic push_tx8(input logic [7:0] d);
    tx_data8  = d;
    tx_valid8 = 1'b1;
    tick(1);
    tx_valid8 = 1'b0;
  endtask

  initial begin
    // Write frame 0x00,0x11,0x22,0x33 then read frame 0x80 with TX = A5,5A.
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'h11, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h22, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 5'd3, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h80, 1'b1, 8'hA5, 5'd0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 5'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 5'd0, 1'b0, 1'b1};

    rst_n = 1'b0; pclk = 1'b0; pcs_n = 1'b1; hbus = '0; err_clr = 1'b0;
    rx_ready8 = 1'b0; tx_data8 = '0; tx_valid8 = 1'b0;
    rx_ready16 = 1'b1; tx_data16 = '0; tx_valid16 = 1'b0;
    tick(3);

    // Reset values
    check("rst_out",   32'(pdata_out8), 32'h0);
    check("rst_oe",    32'(oe8),        32'h0);
    check("rst_rxv",   32'(rx_valid8),  32'h0);
    check("rst_txr",   32'(tx_ready8),  32'h1);
    check("rst_lvl",   32'(rx_level8),  32'h0);
    check("rst_ovf",   32'(ovf8),       32'h0);
    check("rst_unf",   32'(unf8),       32'h0);
    rst_n = 1'b1;
    tick(3);

    // Write frame
    for (int i = 0; i < 4; i++) apply_vec(i);
    pop8("wr0", 8'h11);
    pop8("wr1", 8'h22);
    pop8("wr2", 8'h33);
    check("wr_empty", 32'(rx_valid8), 32'h0);

    // Read frame
    push_tx8(8'hA5);
    push_tx8(8'h5A);
    for (int i = 4; i < 7; i++) apply_vec(i);
    check("rd_end_oe",  32'(oe8),        32'h0);
    check("rd_end_out", 32'(pdata_out8), 32'h0);
    pulse_err_clr();
    check("unf_clr", 32'(unf8), 32'h0);

    // Overflow: 18 words into a 16-deep RX with rx_ready low
    cs_begin();
    host_strobe(16'h0000);
    for (int i = 1; i <= 18; i++) host_strobe(16'(i));
    check("ovf_lvl", 32'(rx_level8), 32'd16);
    check("ovf_flag", 32'(ovf8), 32'h1);
    cs_finish();
    pulse_err_clr();
    check("ovf_clr", 32'(ovf8), 32'h0);
    for (int i = 1; i <= 16; i++) pop8($sformatf("ovf_pop%0d", i), 8'(i));
    check("ovf_drained", 32'(rx_valid8), 32'h0);

    // CS abort: pcs_n rises together with a strobe inside WRITE
    cs_begin();
    host_strobe(16'h0000);
    hbus = 16'h0099;
    tick(2);
    pclk = 1'b1;
    pcs_n = 1'b1;
    tick(8);
    pclk = 1'b0;
    tick(6);
    check("abort_lvl", 32'(rx_level8), 32'h0);
    check("abort_oe",  32'(oe8),       32'h0);
    check("abort_ovf", 32'(ovf8),      32'h0);
    cs_begin();
    host_strobe(16'h0000);
    host_strobe(16'h0042);
    cs_finish();
    pop8("abort_next", 8'h42);

    // Reset in the middle of a read frame
    push_tx8(8'h3C);
    push_tx8(8'hC3);
    cs_begin();
    host_strobe(16'h0080);
    check("mid_oe",  32'(oe8),        32'h1);
    check("mid_out", 32'(pdata_out8), 32'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_oe",  32'(oe8),        32'h0);
    check("mrst_out", 32'(pdata_out8), 32'h0);
    check("mrst_rxv", 32'(rx_valid8),  32'h0);
    check("mrst_txr", 32'(tx_ready8),  32'h1);
    check("mrst_lvl", 32'(rx_level8),  32'h0);
    pcs_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    cs_begin();
    host_strobe(16'h0000);
    host_strobe(16'h0077);
    check("post_oe", 32'(oe8), 32'h0);
    cs_finish();
    pop8("post_rst", 8'h77);
    // TX was flushed by reset: a read now underflows.
    cs_begin();
    host_strobe(16'h0080);
    check("post_txflush_out", 32'(pdata_out8), 32'h0);
    check("post_txflush_unf", 32'(unf8),       32'h1);
    cs_finish();

    // Parameter sweep on the 16-bit instance
    pulse_err_clr();
    rx_ready16 = 1'b0;
    tick(1);
    check("w16_lvl0", 32'(rx_level16), 32'h0);
    cs_begin();
    host_strobe(16'h8000);
    check("w16_rd_oe",  32'(oe16),        32'h1);
    check("w16_rd_out", 32'(pdata_out16), 32'h0);
    check("w16_rd_unf", 32'(unf16),       32'h1);
    cs_finish();
    check("w16_end_oe", 32'(oe16), 32'h0);
    cs_begin();
    host_strobe(16'h7FFF);
    host_strobe(16'h1234);
    check("w16_wr_oe",  32'(oe16),       32'h0);
    check("w16_wr_lvl", 32'(rx_level16), 32'h1);
    check("w16_wr_vld", 32'(rx_valid16), 32'h1);
    check("w16_wr_dat", 32'(rx_data16),  32'h1234);
    cs_finish();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parallel_bus_slave.md
# parallel_bus_slave

Parametrised slave for the Raspberry Pi parallel header: brings the host strobe, chip select and data bus into the CLK_50 domain, decodes a one-word frame header, and moves words in both directions through internal FIFOs. Sits between the RP[] pins at the top level and FPGA-side producers/consumers (e.g. the accelerometer readout). Successor to the fixed 8-bit receive-only link: adds width/depth parameters, host reads, flow control and error flags.

## Interface
- DATA_W, 8: host bus width; header uses the MSB.
- RX_DEPTH, 16: host-to-FPGA FIFO depth in words; power of two, ≥2.
- TX_DEPTH, 16: FPGA-to-host FIFO depth in words; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on pclk, pcs_n and pdata_in; ≥2.

- CLK_50  in  1  system clock; the block's only clock.
- iRSTN  in  1  asynchronous, active-low reset.
- pclk  in  1  host strobe; host drives/samples data on its rising edge.
- pcs_n  in  1  host chip select, active-low; frames one transfer.
- pdata_in  in  DATA_W  host bus, input side.
- pdata_out  out  DATA_W  host bus, output side.
- pdata_oe  out  1  top-level tristate enable for pdata_out.
- rx_data  out  DATA_W  head of RX FIFO (first-word fall-through).
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  pop RX when rx_valid & rx_ready.
- tx_data  in  DATA_W  word to queue for host reads.
- tx_valid  in  1  push request.
- tx_ready  out  1  TX FIFO not full; push when tx_valid & tx_ready.
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- rx_overflow  out  1  sticky: host word dropped, RX full.
- tx_underflow  out  1  sticky: host read with TX empty.
- err_clr  in  1  one-cycle pulse clears both sticky flags.

## Operation
- Synchronise pclk, pcs_n, pdata_in through SYNC_STAGES flops; one further register for edge detect. Strobe event = synced pclk 0→1 while synced pcs_n low.
- FSM: IDLE, HEADER, WRITE, READ.
  - IDLE: pcs_n synced falling → HEADER.
  - HEADER: first strobe captures header; header[DATA_W-1]=1 → READ, else → WRITE. Remaining header bits ignored.
  - WRITE: each strobe pushes synced pdata_in into RX FIFO; if full, word dropped, rx_overflow set.
  - READ: on entry, pdata_oe=1 and pdata_out = TX head (popped on entry). Each strobe pops next TX word onto pdata_out. TX empty at a pop → pdata_out=0, tx_underflow set.
  - Any state: synced pcs_n high → IDLE; pdata_oe=0 next cycle. Word held in pdata_out when frame ends is discarded.
- Simultaneous pcs_n rise and strobe in same cycle: deassert wins, strobe ignored.
- FIFO push and pop in same cycle: both occur, level unchanged; push when full with same-cycle pop is accepted (no overflow).
- err_clr concurrent with a new error: flag stays set.
- Reset mid-frame: FSM → IDLE, FIFOs emptied; a frame in progress is lost, host must re-assert pcs_n.

## Timing
- Reset values: pdata_out=0, pdata_oe=0, rx_valid=0, tx_ready=1, rx_level=0, rx_overflow=0, tx_underflow=0, FSM=IDLE.
- Write latency: rx_valid/rx_data updated SYNC_STAGES+2 CLK_50 cycles after pclk rise at pin (RX empty).
- Read latency: new pdata_out valid SYNC_STAGES+2 cycles after pclk rise; pdata_oe rises SYNC_STAGES+2 cycles after header strobe.
- Host constraints: pclk high and low each ≥ SYNC_STAGES+3 CLK_50 cycles; pdata_in stable from ≥1 cycle before pclk rise to SYNC_STAGES+2 cycles after.
- FPGA side: single-cycle valid/ready handshakes, no combinational ready→valid paths.

## Structure
- Package parallel_pkg: FSM state enum, HDR_READ_BIT = DATA_W-1 function/constant.
- Sub-module sync_fifo (params WIDTH, DEPTH; FWFT, level output), instantiated for RX and TX.

## Test plan
- Write frame: header 0x00, words 0x11,0x22,0x33 → rx_data 0x11,0x22,0x33 in order, rx_level 3, rx_overflow 0.
- Read frame: preload TX 0xA5,0x5A; header 0x80 → pdata_oe=1, host samples 0xA5 then 0x5A; third strobe → 0x00 and tx_underflow=1.
- Overflow: RX_DEPTH=16, rx_ready=0, 18 write words → rx_level 16, words 17–18 dropped, rx_overflow=1; err_clr → 0.
- CS abort: pcs_n rises together with a strobe in WRITE → no push, FSM IDLE, pdata_oe 0.
- Reset mid-read: iRSTN low during READ → all outputs to reset values immediately; next frame with header 0x00 works.
- Parameter sweep: DATA_W=16, RX_DEPTH=4 → header 0x8000 selects READ, 0x7FFF selects WRITE.
